// File: rtl/uart_rx_frame_receiver.sv
// UART receiver: 2-flop synchronised RX_IN, oversampled 2-of-3 mid-bit vote,
// optional parity and stop checking, one result pulse per frame.
`timescale 1ns/100ps
module uart_rx_frame_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int EW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int H  = OVERSAMPLE / 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic                  rx_m, rx_s;
    logic [EW-1:0]         edge_cnt, low_run;
    logic [BW-1:0]         bit_cnt;
    logic [2:0]            smp;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  perr, brk, par_en_q, par_typ_q;
    logic                  vote, vote_now, bit_end, last_bit;
    logic                  start_frame, fin_ok, fin_perr, fin_stp;

    assign vote     = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign vote_now = (edge_cnt == EW'(H + 2));
    assign bit_end  = (edge_cnt == EW'(OVERSAMPLE - 1));
    assign last_bit = (bit_cnt == BW'(DATA_WIDTH - 1));
    assign busy     = (state_q != IDLE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= RX_IN;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        fin_ok      = 1'b0;
        fin_perr    = 1'b0;
        fin_stp     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s && !brk) begin
                    state_d     = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                if (vote_now && vote) state_d = IDLE;
                else if (bit_end)     state_d = DATA;
            end
            DATA: begin
                if (bit_end && last_bit) state_d = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (vote_now) begin
                    state_d = IDLE;
                    if (!vote)     fin_stp  = 1'b1;
                    else if (perr) fin_perr = 1'b1;
                    else           fin_ok   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // low_run counts rx_s low cycles already elapsed; a start edge that arrived
    // while STOP was still finishing is then picked up at its true bit phase.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt  <= '0;
            low_run   <= '0;
            bit_cnt   <= '0;
            smp       <= 3'b111;
            shift_reg <= '0;
            perr      <= 1'b0;
            brk       <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            if (start_frame)                       edge_cnt <= low_run;
            else if (state_q == IDLE || bit_end)   edge_cnt <= '0;
            else                                   edge_cnt <= edge_cnt + 1'b1;

            if (rx_s)                              low_run <= '0;
            else if (low_run != EW'(H - 1))        low_run <= low_run + 1'b1;

            if (edge_cnt == EW'(H - 1)) smp[0] <= rx_s;
            if (edge_cnt == EW'(H))     smp[1] <= rx_s;
            if (edge_cnt == EW'(H + 1)) smp[2] <= rx_s;

            if (state_q == START)                  bit_cnt <= '0;
            else if (state_q == DATA && bit_end)   bit_cnt <= bit_cnt + 1'b1;

            if (state_q == DATA && vote_now) shift_reg[bit_cnt] <= vote;

            if (state_q == IDLE)
                perr <= 1'b0;
            else if (state_q == PARITY && vote_now && (vote != (^shift_reg ^ par_typ_q)))
                perr <= 1'b1;

            // a held-low line after a stop error must go high before a new start
            if (fin_stp)                           brk <= 1'b1;
            else if (state_q == IDLE && rx_s)      brk <= 1'b0;

            if (start_frame) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            P_DATA     <= '0;
            Data_Valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            Data_Valid <= fin_ok;
            par_err    <= fin_perr;
            stp_err    <= fin_stp;
            if (fin_ok) P_DATA <= shift_reg;
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// Scoreboard bench for uart_rx_frame_receiver: frames are serialised by the
// bench, expected result pulses are queued and matched as the DUT reports them.
`timescale 1ns/100ps
module tb_uart_rx_frame_receiver;

    localparam int DW = 8;
    localparam int OS = 8;
    localparam real BIT  = 80.0;
    localparam real FAST = 80.0 / 1.03;
    localparam real SLOW = 80.0 * 1.03;

    typedef struct {
        logic [2:0]    flags;
        logic [DW-1:0] data;
    } exp_t;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          Data_Valid, par_err, stp_err, busy;

    exp_t          sb[$];
    int            checks = 0;
    int            failures = 0;

    localparam logic [2:0] F_OK = 3'b100, F_PAR = 3'b010, F_STP = 3'b001;

    uart_rx_frame_receiver #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .P_DATA(P_DATA), .Data_Valid(Data_Valid), .par_err(par_err),
        .stp_err(stp_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin : mon
        exp_t e;
        if (RST && (Data_Valid || par_err || stp_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {29'd0, Data_Valid, par_err, stp_err}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("flags", {29'd0, Data_Valid, par_err, stp_err}, {29'd0, e.flags});
                chk("p_data", {24'd0, P_DATA}, {24'd0, e.data});
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    function automatic logic par_of(input logic [DW-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    task automatic expect_res(input logic [2:0] f, input logic [DW-1:0] d);
        exp_t e;
        e.flags = f;
        e.data  = d;
        sb.push_back(e);
    endtask

    // start the line transition just before a rising edge
    task automatic align();
        @(posedge CLK);
        #9;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pen, input logic pbit,
                              input logic stop, input real bt);
        RX_IN = 1'b0;
        #(bt);
        for (int i = 0; i < DW; i++) begin
            RX_IN = d[i];
            #(bt);
        end
        if (pen) begin
            RX_IN = pbit;
            #(bt);
        end
        RX_IN = stop;
        #(bt);
    endtask

    task automatic drain(input string tag);
        repeat (30) @(posedge CLK);
        chk(tag, sb.size(), 32'd0);
    endtask

    initial begin
        // reset state
        #23;
        chk("rst_p_data", {24'd0, P_DATA}, 32'd0);
        chk("rst_dv", {31'd0, Data_Valid}, 32'd0);
        chk("rst_par_err", {31'd0, par_err}, 32'd0);
        chk("rst_stp_err", {31'd0, stp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        RST = 1'b1;
        repeat (5) @(posedge CLK);

        // T1: no parity
        PAR_EN = 1'b0;
        align();
        expect_res(F_OK, 8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, BIT);
        drain("t1_pending");

        // T2: even parity, good then bad
        PAR_EN = 1'b1; PAR_TYP = 1'b0;
        align();
        expect_res(F_OK, 8'h3C);
        send_frame(8'h3C, 1'b1, par_of(8'h3C, 1'b0), 1'b1, BIT);
        drain("t2_good_pending");
        align();
        expect_res(F_PAR, 8'h3C);
        send_frame(8'h3C, 1'b1, ~par_of(8'h3C, 1'b0), 1'b1, BIT);
        drain("t2_bad_pending");
        align();
        expect_res(F_PAR, 8'h3C);
        send_frame(8'h5A, 1'b1, ~par_of(8'h5A, 1'b0), 1'b1, BIT);
        drain("t2_bad2_pending");

        // T3: odd parity, stop bit 0 followed by a held-low line
        PAR_TYP = 1'b1;
        align();
        expect_res(F_STP, 8'h3C);
        send_frame(8'h01, 1'b1, par_of(8'h01, 1'b1), 1'b0, BIT);
        #(1.5 * BIT);
        chk("t3_busy_in_break", {31'd0, busy}, 32'd0);
        #(1.5 * BIT);
        RX_IN = 1'b1;
        drain("t3_pending");
        chk("t3_busy_after", {31'd0, busy}, 32'd0);

        // T4: 2-cycle glitch while idle
        PAR_EN = 1'b0; PAR_TYP = 1'b0;
        align();
        RX_IN = 1'b0;
        #20;
        RX_IN = 1'b1;
        @(negedge CLK);
        chk("t4_busy_false_start", {31'd0, busy}, 32'd1);
        repeat (20) @(posedge CLK);
        #1;
        chk("t4_busy_after", {31'd0, busy}, 32'd0);
        drain("t4_pending");

        // T5: back-to-back frames at slow then fast baud
        align();
        expect_res(F_OK, 8'h55); expect_res(F_OK, 8'hFF); expect_res(F_OK, 8'h00);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, SLOW);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, SLOW);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, SLOW);
        drain("t5_slow_pending");
        align();
        expect_res(F_OK, 8'h55); expect_res(F_OK, 8'hFF); expect_res(F_OK, 8'h00);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, FAST);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, FAST);
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, FAST);
        drain("t5_fast_pending");

        // T6: reset in the middle of a frame
        align();
        expect_res(F_OK, 8'hC3);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, BIT);
        drain("t6_pre_pending");
        align();
        fork
            send_frame(8'h81, 1'b0, 1'b0, 1'b1, BIT);
        join_none
        #(5.5 * BIT);
        chk("t6_busy_before_rst", {31'd0, busy}, 32'd1);
        RST = 1'b0;
        #1;
        chk("t6_rst_p_data", {24'd0, P_DATA}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_flags", {29'd0, Data_Valid, par_err, stp_err}, 32'd0);
        wait fork;
        repeat (3) @(posedge CLK);
        RST = 1'b1;
        repeat (5) @(posedge CLK);
        align();
        expect_res(F_OK, 8'h7E);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, BIT);
        drain("t6_pending");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
